// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl -- double-buffer exchange scheduler for the LED framebuffer.
//
// The writer fills the write bank and holds `full`. The scanout drains the read
// bank and pulses `frame_end` on the last pixel of each displayed frame. Banks
// exchange only on a frame boundary, and only once the current read buffer has
// been shown for at least MIN_SHOW frames.
//
// Parameters:
//   MIN_SHOW   minimum display frames per buffer before the next swap (1..255)
//   CNT_W      width of the swap / repeat statistics counters
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          swap enable
//   full        writer has a complete frame in the write bank (level)
//   frame_end   one-cycle pulse at the end of each displayed frame
//   swapped     one-cycle pulse, banks exchanged this cycle
//   wr_bank     bank targeted by the writer
//   rd_bank     bank read by scanout, always ~wr_bank
//   pending     frame ready, waiting for a frame boundary
//   swap_cnt    swaps since reset, wraps
//   repeat_cnt  surplus repeated display frames, saturates
module fb_swap_ctrl #(
    parameter int unsigned MIN_SHOW = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             full,
    input  logic             frame_end,
    output logic             swapped,
    output logic             wr_bank,
    output logic             rd_bank,
    output logic             pending,
    output logic [CNT_W-1:0] swap_cnt,
    output logic [CNT_W-1:0] repeat_cnt
);

    typedef enum logic [1:0] {
        StFill,
        StArmed,
        StSwap
    } state_e;

    localparam logic [7:0]       MinShow = 8'(MIN_SHOW);
    localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

    state_e     state_q;
    state_e     state_d;
    logic [7:0] shown_cnt_q;
    logic [8:0] shown_sum;
    logic       shown_ok;
    logic       swap_go;
    logic       do_swap;
    logic       is_repeat;

    // The frame_end of this very cycle counts toward the display requirement.
    assign shown_sum = {1'b0, shown_cnt_q} + {8'd0, frame_end};
    assign shown_ok  = shown_sum >= {1'b0, MinShow};
    assign swap_go   = frame_end & shown_ok;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill: begin
                if (full && en && swap_go) begin
                    state_d = StSwap;
                end else if (full && en) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                // Disable wins over a coincident boundary; a dropped `full`
                // is a writer protocol error and simply abandons the request.
                if (!en || !full) begin
                    state_d = StFill;
                end else if (swap_go) begin
                    state_d = StSwap;
                end
            end
            // `full` is deliberately ignored here: it is still clearing.
            StSwap:  state_d = StFill;
            default: state_d = StFill;
        endcase
    end

    assign do_swap   = (state_d == StSwap);
    // A boundary beyond the requirement that did not retire the buffer.
    assign is_repeat = frame_end && !do_swap && (shown_cnt_q >= MinShow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFill;
            shown_cnt_q <= MinShow;   // first ready frame is not held back
            swapped     <= 1'b0;
            pending     <= 1'b0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b1;
            swap_cnt    <= '0;
            repeat_cnt  <= '0;
        end else begin
            state_q <= state_d;
            swapped <= do_swap;
            pending <= (state_d == StArmed);

            if (do_swap) begin
                wr_bank     <= ~wr_bank;
                rd_bank     <= ~rd_bank;
                swap_cnt    <= swap_cnt + CntOne;
                shown_cnt_q <= 8'd0;
            end else if (frame_end && (shown_cnt_q < MinShow)) begin
                shown_cnt_q <= shown_cnt_q + 8'd1;
            end

            if (is_repeat && (repeat_cnt != CntMax)) begin
                repeat_cnt <= repeat_cnt + CntOne;
            end
        end
    end

endmodule

// File: doc/fb_swap_ctrl.md
Name: fb_swap_ctrl

Overview:
Double-buffer scheduler for the LED framebuffer. The FTDI writer fills the write bank and raises `full`. The display scanout drains the read bank and pulses `frame_end` at the end of each displayed frame. This block decides when the banks exchange, emits the one-cycle `swapped` pulse that releases the writer, and keeps frame statistics for debug readout.

Parameters:
MIN_SHOW, 1, minimum number of display frames a new buffer is shown before the next swap is allowed; legal range 1..255
CNT_W, 16, width of the swap and repeat statistics counters

Ports:
clk  in  1  system clock; all logic is on its rising edge
rst_n  in  1  asynchronous, active-low reset
en  in  1  swap enable; when low, no swap is scheduled
full  in  1  level from the writer: the write bank holds a complete frame; stays high until the cycle after `swapped`
frame_end  in  1  single-cycle pulse from scanout on the last pixel of a displayed frame
swapped  out  1  single-cycle pulse; the banks exchanged this cycle
wr_bank  out  1  bank index the writer targets
rd_bank  out  1  bank index the scanout reads; always equal to ~wr_bank
pending  out  1  high while in ARMED (frame ready, waiting for a boundary)
swap_cnt  out  CNT_W  number of swaps since reset; wraps modulo 2^CNT_W
repeat_cnt  out  CNT_W  number of surplus repeated display frames; saturates at all-ones

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - state = FILL; wr_bank = 0; rd_bank = 1; swapped = 0; pending = 0; swap_cnt = 0; repeat_cnt = 0.
  - shown_cnt (8-bit internal) = MIN_SHOW, so the first ready frame is not held back.
- shown_ok = (shown_cnt + frame_end) >= MIN_SHOW. The frame_end pulse in the current cycle counts toward the requirement.
- swap_go = frame_end && shown_ok.
- States and transitions:
  - FILL:
    - If full && en && swap_go -> SWAP.
    - Else if full && en -> ARMED.
    - Else stay in FILL.
  - ARMED:
    - If !en -> FILL; `full` stays high and the writer remains stalled.
    - Else if swap_go -> SWAP.
    - Else stay in ARMED.
    - Loss of `full` while ARMED is illegal. The block returns to FILL without swapping.
  - SWAP:
    - Lasts exactly one cycle, then -> FILL unconditionally.
    - `full` is not sampled in SWAP. This prevents a double swap while the writer's `full` is still clearing.
- On the edge entering SWAP (all registered, visible during the SWAP cycle):
  - wr_bank and rd_bank toggle.
  - swapped = 1.
  - swap_cnt increments.
  - shown_cnt clears to 0.
- swapped is high only in SWAP. pending is high only in ARMED.
- Latency: a frame_end that satisfies swap_go gives swapped=1 and the new banks on the next cycle (1 clk). `full`, if already high, is registered into a state change in 1 clk.
- shown_cnt increments on each frame_end and saturates at MIN_SHOW.
  - A frame_end during the SWAP cycle counts for the new buffer (0 -> 1).
- repeat_cnt increments (saturating) on each frame_end that does not cause a swap while shown_cnt is already >= MIN_SHOW. In other words, the display re-showed a frame beyond the requirement.
  - A frame_end that only raises shown_cnt toward MIN_SHOW is not a repeat.
- Simultaneous events:
  - full rising together with a qualifying frame_end in FILL swaps directly (FILL->SWAP); ARMED is skipped.
  - en falling in the same cycle as swap_go in ARMED: disable wins and no swap occurs.
- Reset mid-SWAP: the banks return to 0/1 and the swap is not counted. After reset the writer still holds `full` and is re-served normally.

Test Plan:
1. MIN_SHOW=1. Reset, en=1, full=1 at cycle 5, frame_end at cycle 20 -> pending=1 for cycles 6..20; swapped=1 only at cycle 21; wr_bank=1, rd_bank=0, swap_cnt=1 from cycle 21.
2. MIN_SHOW=3. After swap 1, hold full=1 and pulse frame_end at cycles 100/200/300 -> no swap at 101/201; swapped=1 at 301; repeat_cnt stays 0.
3. MIN_SHOW=1, full=0, five frame_end pulses -> repeat_cnt=5, swap_cnt=0, banks unchanged.
4. en=0, full=1, frame_end pulsed -> no swap and pending=0. Raise en -> ARMED next cycle; next frame_end swaps.
5. full rising and frame_end both in cycle 10 while in FILL -> swapped=1 at cycle 11; pending never high.
6. Assert rst_n=0 during the SWAP cycle -> wr_bank=0, swapped=0, swap_cnt=0 immediately. Release with full still high -> one swap on the next frame_end.
